fp_mult_seq: RTL
================

Name: fp_mult_seq

Overview:
- Sequential IEEE-754 multiplier core that consumes operand classification (nan/inf/norm/zero/denorm) and produces the product.
- Sits directly downstream of the operand classifier in the real-multiplier path.
- Handles special cases in one cycle.
- Normal operands use an iterative shift-add mantissa multiply, then normalise, apply exponent arithmetic and truncate.
- Valid/ready handshake on both input and output sides.

Parameters:
- IS_DOUBLE, 0, 1 selects binary64, 0 selects binary32.
- WIDTH, IS_DOUBLE ? 64 : 32, total operand width.
- EXPONENT_W, IS_DOUBLE ? 11 : 8, exponent field width.
- MANTISSA_W, IS_DOUBLE ? 52 : 23, stored fraction width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  operands valid.
- ready_o  output  1  block can accept operands (high only in IDLE).
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- valid_o  output  1  res valid.
- ready_i  input  1  consumer accepts res.
- res  output  WIDTH  product.

Behaviour:
- Reset: state=IDLE, ready_o=1, valid_o=0, res=0, all internal registers 0. Reset mid-operation abandons the computation; no result is produced.
- FSM states: IDLE, MULT, NORM, DONE.
- IDLE:
  - Accept on valid_i & ready_o; latch op1/op2 and classify both.
  - Special result → DONE next cycle (valid_o at acceptance+1).
  - Otherwise → MULT.
- Special-case priority, evaluated at acceptance; sign s = op1[WIDTH-1] ^ op2[WIDTH-1]:
  - (1) either operand NaN → canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
  - (2) inf × zero, either order → canonical qNaN.
  - (3) either inf → {s, all-ones exp, 0}.
  - (4) either zero → {s, 0, 0}.
  - Denormal inputs are flushed to zero and fall under (4).
- MULT:
  - Significands {1, fraction} (MANTISSA_W+1 bits).
  - One shift-add step per cycle for exactly MANTISSA_W+1 cycles, using a counter.
  - Product register is 2*(MANTISSA_W+1) bits.
- Exponent arithmetic:
  - Computed in IDLE→MULT as signed EXPONENT_W+2 bits: e = e1 + e2 − bias, bias = 2^(EXPONENT_W−1) − 1.
- NORM (one cycle):
  - If product MSB = 1: fraction = product bits below MSB, top MANTISSA_W; e = e + 1.
  - Else: fraction taken one bit lower.
  - Rounding is truncation (round toward zero); discarded bits are ignored.
  - e ≥ all-ones → {s, all-ones, 0} (infinity).
  - e ≤ 0 → {s, 0, 0} (flush to zero).
  - Else → {s, e[EXPONENT_W−1:0], fraction}.
- Normal-path latency: valid_o rises MANTISSA_W+3 cycles after the acceptance cycle (26 for binary32).
- DONE:
  - res held stable, valid_o=1, ready_o=0.
  - On ready_i → IDLE, valid_o=0 next cycle.
  - ready_i while not in DONE is ignored.
  - No new acceptance occurs in the same cycle as result hand-off; one bubble is required.
- valid_i held while busy is ignored; no queuing.

Decomposition:
- Shared package fp_pkg:
  - Format localparams: bias, qNaN pattern, all-ones exponent, per-format widths derived from IS_DOUBLE.
  - FSM state enum.
  - Class-flag struct {nan, inf, norm, zero, denorm}.
- One sub-module: fp_class_decode, purely combinational per operand, producing the class-flag struct.
- fp_mult_seq instantiates fp_class_decode twice.
- Shift-add datapath stays inline.

Test Plan:
- Normal, exact: binary32 0x40000000 × 0x40400000 (2×3) → res 0x40C00000 exactly 26 cycles after acceptance; ready_o low throughout.
- Normalisation carry: 0x3FC00000 × 0x3FC00000 (1.5×1.5) → 0x40100000; product MSB=1 path with exponent increment.
- Special cases:
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0xC0000000 × 0x7F800000 → 0xFF800000.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000.
  - Each special result is valid 1 cycle after acceptance.
- Overflow/underflow:
  - 0x7F000000 × 0x7F000000 → 0x7F800000.
  - 0x00800000 × 0x00800000 → 0x00000000.
  - Denormal 0x00000001 × 0x40000000 → 0x00000000.
- Back-pressure: hold ready_i=0 for 10 cycles after valid_o → res and valid_o stable; release → valid_o low next cycle, ready_o high.
- Reset mid-MULT:
  - Assert rst at cycle 10 of a multiply → next cycle IDLE, valid_o=0, res=0.
  - A following 0x3F800000 × 0x3F800000 → 0x3F800000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential IEEE-754 multiplier: format constants,
// FSM state encoding and the operand class-flag bundle.
package fp_pkg;

  localparam int SP_WIDTH = 32;
  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int DP_WIDTH = 64;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 52;

  localparam logic [63:0] SP_QNAN = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic norm;
    logic zero;
    logic denorm;
  } fp_class_t;

  function automatic int fmt_width(input bit is_double);
    return is_double ? DP_WIDTH : SP_WIDTH;
  endfunction

  function automatic int fmt_exp_w(input bit is_double);
    return is_double ? DP_EXP_W : SP_EXP_W;
  endfunction

  function automatic int fmt_man_w(input bit is_double);
    return is_double ? DP_MAN_W : SP_MAN_W;
  endfunction

  function automatic int fmt_bias(input bit is_double);
    return (1 << (fmt_exp_w(is_double) - 1)) - 1;
  endfunction

  function automatic logic [63:0] fmt_qnan(input bit is_double);
    return is_double ? DP_QNAN : SP_QNAN;
  endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational IEEE-754 operand classifier; takes exponent and fraction
// fields (sign excluded) and raises exactly one class flag.
module fp_class_decode
  import fp_pkg::*;
#(
  parameter int EXPONENT_W = 8,
  parameter int MANTISSA_W = 23
) (
  input  logic [EXPONENT_W+MANTISSA_W-1:0] op_i,
  output fp_class_t                        class_o
);

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;

  // NOTE: every output of a combinational block gets a value on every path
  // (here a default first); otherwise synthesis infers a latch.
  always_comb begin
    class_o   = '0;
    exp_ones  = &op_i[EXPONENT_W+MANTISSA_W-1:MANTISSA_W];
    exp_zero  = ~|op_i[EXPONENT_W+MANTISSA_W-1:MANTISSA_W];
    frac_zero = ~|op_i[MANTISSA_W-1:0];

    class_o.nan    = exp_ones & ~frac_zero;
    class_o.inf    = exp_ones & frac_zero;
    class_o.zero   = exp_zero & frac_zero;
    class_o.denorm = exp_zero & ~frac_zero;
    class_o.norm   = ~exp_ones & ~exp_zero;
  end

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 multiplier: special operands resolve in one cycle,
// normal operands go through a shift-add mantissa multiply, normalise, truncate.
module fp_mult_seq
  import fp_pkg::*;
#(
  parameter bit IS_DOUBLE  = 1'b0,
  parameter int WIDTH      = fmt_width(IS_DOUBLE),
  parameter int EXPONENT_W = fmt_exp_w(IS_DOUBLE),
  parameter int MANTISSA_W = fmt_man_w(IS_DOUBLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] res
);

  localparam int SIG_W  = MANTISSA_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXPONENT_W + 2;
  localparam int CNT_W  = $clog2(SIG_W + 1);

  localparam logic [EXPONENT_W-1:0]  EXP_ONES = '1;
  localparam logic signed [E_W-1:0]  EXP_MAX  = signed'({2'b00, EXP_ONES});
  localparam logic signed [E_W-1:0]  BIAS     = E_W'(fmt_bias(IS_DOUBLE));
  localparam logic [WIDTH-1:0]       QNAN     = WIDTH'(fmt_qnan(IS_DOUBLE));
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(SIG_W - 1);

  state_t                  state_q;
  logic                    ready_q;
  logic                    valid_q;
  logic [WIDTH-1:0]        res_q;
  logic                    sign_q;
  logic signed [E_W-1:0]   exp_q;
  logic [PROD_W-1:0]       mcand_q;
  logic [SIG_W-1:0]        mplier_q;
  logic [PROD_W-1:0]       prod_q;
  logic [CNT_W-1:0]        cnt_q;

  fp_class_t cls1;
  fp_class_t cls2;

  fp_class_decode #(
    .EXPONENT_W (EXPONENT_W),
    .MANTISSA_W (MANTISSA_W)
  ) u_dec_op1 (
    .op_i    (op1[WIDTH-2:0]),
    .class_o (cls1)
  );

  fp_class_decode #(
    .EXPONENT_W (EXPONENT_W),
    .MANTISSA_W (MANTISSA_W)
  ) u_dec_op2 (
    .op_i    (op2[WIDTH-2:0]),
    .class_o (cls2)
  );

  logic                   sign_d;
  logic                   special_d;
  logic [WIDTH-1:0]       special_res_d;
  logic signed [E_W-1:0]  exp_d;
  logic                   z1;
  logic                   z2;

  // Acceptance-time decisions; denormals count as zero.
  always_comb begin
    sign_d        = op1[WIDTH-1] ^ op2[WIDTH-1];
    z1            = cls1.zero | cls1.denorm;
    z2            = cls2.zero | cls2.denorm;
    special_d     = ~(cls1.norm & cls2.norm);
    special_res_d = '0;
    exp_d         = signed'({2'b00, op1[WIDTH-2 -: EXPONENT_W]})
                  + signed'({2'b00, op2[WIDTH-2 -: EXPONENT_W]}) - BIAS;

    if (cls1.nan || cls2.nan) begin
      special_res_d = QNAN;
    end else if ((cls1.inf && z2) || (cls2.inf && z1)) begin
      special_res_d = QNAN;
    end else if (cls1.inf || cls2.inf) begin
      special_res_d = {sign_d, EXP_ONES, {MANTISSA_W{1'b0}}};
    end else if (z1 || z2) begin
      special_res_d = {sign_d, {(WIDTH-1){1'b0}}};
    end
  end

  logic                   prod_msb;
  logic [MANTISSA_W-1:0]  frac_d;
  logic signed [E_W-1:0]  exp_adj_d;
  logic [WIDTH-1:0]       norm_res_d;

  // Normalise the finished product; discarded low bits truncate toward zero.
  always_comb begin
    prod_msb   = prod_q[PROD_W-1];
    frac_d     = prod_msb ? prod_q[PROD_W-2 -: MANTISSA_W]
                          : prod_q[PROD_W-3 -: MANTISSA_W];
    exp_adj_d  = exp_q + signed'({{(E_W-1){1'b0}}, prod_msb});
    norm_res_d = {sign_q, exp_adj_d[EXPONENT_W-1:0], frac_d};

    if (exp_adj_d >= EXP_MAX) begin
      norm_res_d = {sign_q, EXP_ONES, {MANTISSA_W{1'b0}}};
    end else if (exp_adj_d <= 0) begin
      norm_res_d = {sign_q, {(WIDTH-1){1'b0}}};
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      res_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            ready_q <= 1'b0;
            sign_q  <= sign_d;
            if (special_d) begin
              res_q   <= special_res_d;
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              mcand_q  <= PROD_W'({1'b1, op1[MANTISSA_W-1:0]});
              mplier_q <= {1'b1, op2[MANTISSA_W-1:0]};
              prod_q   <= '0;
              cnt_q    <= '0;
              exp_q    <= exp_d;
              state_q  <= MULT;
            end
          end
        end
        MULT: begin
          if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          res_q   <= norm_res_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          // Hand-off returns to IDLE; acceptance waits one more cycle.
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign res     = res_q;

endmodule
